// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data memory.
// Width encodings are also used by the core's memcontrol.
package lsu_pkg;

  localparam logic [1:0] W_BYTE   = 2'b00;
  localparam logic [1:0] W_HALF   = 2'b01;
  localparam logic [1:0] W_WORD   = 2'b10;
  localparam logic [1:0] W_DOUBLE = 2'b11;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  function automatic logic align_fault(
    input logic [1:0] w,
    input logic [2:0] a,
    input logic       is64
  );
    logic f;
    f = 1'b0;
    unique case (w)
      W_BYTE:   f = 1'b0;
      W_HALF:   f = a[0];
      W_WORD:   f = |a[1:0];
      W_DOUBLE: f = !is64 || (|a[2:0]);
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Lane insert/extract, byte enables and load extension.
// Purely combinational; faults are resolved by the caller.
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int LW         = $clog2(NB)
) (
  input  logic [1:0]            i_width,
  input  logic [LW-1:0]         i_lane,
  input  logic                  i_usignext,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rword,
  output logic [NB-1:0]         o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [LW+2:0]         w_shift;
  logic [DATA_WIDTH-1:0] w_sh;
  logic [7:0]            w_mask;
  logic [7:0]            w_be8;

  assign w_shift = {i_lane, 3'b000};
  assign w_sh    = i_rword >> w_shift;
  assign o_wdata = i_wdata << w_shift;
  assign w_be8   = w_mask << i_lane;
  assign o_be    = w_be8[NB-1:0];

  always_comb begin
    w_mask  = 8'h00;
    o_rdata = '0;
    unique case (i_width)
      W_BYTE: begin
        w_mask       = 8'h01;
        o_rdata      = {DATA_WIDTH{!i_usignext & w_sh[7]}};
        o_rdata[7:0] = w_sh[7:0];
      end
      W_HALF: begin
        w_mask        = 8'h03;
        o_rdata       = {DATA_WIDTH{!i_usignext & w_sh[15]}};
        o_rdata[15:0] = w_sh[15:0];
      end
      W_WORD: begin
        w_mask        = 8'h0F;
        o_rdata       = {DATA_WIDTH{!i_usignext & w_sh[31]}};
        o_rdata[31:0] = w_sh[31:0];
      end
      W_DOUBLE: begin
        w_mask  = 8'hFF;
        o_rdata = w_sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Pipelined data memory with valid/ready requests, fixed read
// latency responses, alignment faulting and clear-after-reset.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_width,
  input  logic                  req_usignext,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  busy
);

  localparam int   NB   = DATA_WIDTH / 8;
  localparam int   LW   = $clog2(NB);
  localparam int   IW   = $clog2(DEPTH_WORDS);
  localparam logic IS64 = (DATA_WIDTH == 64);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  state_e                r_state;
  logic [IW-1:0]         r_cnt;
  logic                  r_ready;
  logic [READ_LATENCY:0] r_pv;
  logic [READ_LATENCY:0] r_pf;
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY+1];

  logic                  w_acc;
  logic                  w_fault;
  logic                  w_st;
  logic                  w_clr;
  logic [IW-1:0]         w_idx;
  logic [LW-1:0]         w_lane;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_acc   = req_valid & r_ready & !reset;
  assign w_fault = align_fault(req_width, req_addr[2:0], IS64);
  assign w_st    = w_acc & req_we & !w_fault;
  assign w_clr   = (r_state == CLEAR) && (CLEAR_ON_RESET != 0);
  assign w_idx   = req_addr[LW +: IW];
  assign w_lane  = req_addr[LW-1:0];
  assign w_unused = ^req_addr[31:LW+IW];

  lsu_mem_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_width   (req_width),
    .i_lane    (w_lane),
    .i_usignext(req_usignext),
    .i_wdata   (req_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_st) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // Stage 0 captures the access; the last stage drives the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_pv    <= '0;
      r_pf    <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv    <= {r_pv[READ_LATENCY-1:0], w_acc};
      r_pf    <= {r_pf[READ_LATENCY-1:0], w_acc & w_fault};
      r_pd[0] <= (w_acc & !req_we & !w_fault) ? w_rdata : '0;
      for (int i = 1; i <= READ_LATENCY; i++) r_pd[i] <= r_pd[i-1];
      unique case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + IW'(1);
          if (CLEAR_ON_RESET == 0 || r_cnt == IW'(DEPTH_WORDS - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: r_ready <= 1'b1;
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_pv[READ_LATENCY];
  assign resp_fault = r_pf[READ_LATENCY];
  assign resp_rdata = r_pd[READ_LATENCY];
  assign busy       = (r_state == CLEAR) || (|r_pv);

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Parametrised, pipelined data memory that replaces the fixed single-cycle data memory behind the rv32 core.
- Requests use a valid/ready handshake. Responses return after a configurable read latency.
- Supports byte/half/word (and double when 64-bit) little-endian access with sign or zero extension, misalignment faulting, and a clear-on-reset sequencer.
- Sits between the core's memory stage and the top level. A second instance with writes tied off serves as instruction memory.

Parameters:
- DATA_WIDTH, 32, data path width; legal values 32 or 64.
- DEPTH_WORDS, 1024, number of DATA_WIDTH-wide words; power of two.
- READ_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1, zero every word after reset before accepting requests.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_width  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- req_usignext  in  1  1 = zero-extend load data, 0 = sign-extend
- req_wdata  in  DATA_WIDTH  store data, right-aligned (low bits used)
- resp_valid  out  1  response present (single-cycle pulse per request)
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_fault  out  1  request was misaligned or illegal width
- busy  out  1  clear sequence active or responses outstanding

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, busy=1. All pipeline valid bits are cleared.
- FSM states:
  - CLEAR: word counter runs 0..DEPTH_WORDS-1, writing zero at one word per cycle. Go to RUN after the last word (DEPTH_WORDS cycles).
  - RUN: req_ready=1.
- If CLEAR_ON_RESET=0, the block enters RUN on the cycle after reset deasserts, and array contents are retained.
- Reset asserted in any state (including mid-CLEAR or with responses in flight) restarts from the reset values. In-flight responses are dropped and the clear counter restarts at 0.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready. At most one request is accepted per cycle.
- No response backpressure exists; the consumer must sink every response.
- Index: word index = req_addr[log2(DEPTH_WORDS*DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Lane = the low address bits (byte offset within the word).
- Fault conditions:
  - req_width==11 when DATA_WIDTH==32.
  - Address not aligned to the access size (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0).
- A faulting request makes no array write and responds with resp_fault=1 and resp_rdata=0.
- Store: writes only the addressed bytes at the acceptance edge; other bytes in the word are unchanged. Value = low 8/16/32/64 bits of req_wdata.
- Load: samples the array at the acceptance edge, so it sees every store accepted in earlier cycles.
  - Extracts the lane, then zero-extends (req_usignext=1) or sign-extends (req_usignext=0).
  - A word load with DATA_WIDTH=64 sign- or zero-extends to 64 bits.
  - A double load ignores usignext.
- Latency: resp_valid rises exactly READ_LATENCY cycles after the acceptance edge, for both loads and stores. Responses are in order; back-to-back requests give back-to-back responses.
- Store responses carry resp_rdata=0 and resp_fault=0 (fault=1 if misaligned).
- busy = (state==CLEAR) || any pipeline stage valid.

Decomposition:
- Shared package lsu_pkg holds:
  - width encodings (W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10, W_DOUBLE=2'b11), which the core's memcontrol also uses;
  - FSM state enum (CLEAR, RUN);
  - a function computing the alignment fault from width and addr low bits.
- One sub-module: lsu_mem_align. It is combinational lane extract/insert plus sign/zero extension and byte-enable generation.
- The top module holds the array, the pipeline registers and the FSM.

Test Plan:
- Clear: DEPTH_WORDS=16, CLEAR_ON_RESET=1, reset 1 cycle -> req_ready=0 for exactly 16 cycles, then 1. A word load from 0x3C then returns 0x00000000.
- Byte/half extension: store word 0x80F17F01 to 0x10, then byte loads from 0x10..0x13 with usignext=0 -> 0x00000001, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80. A half load from 0x12 with usignext=1 -> 0x000080F1.
- Partial store and RAW: store word 0xAABBCCDD to 0x20; in the next cycle store byte 0x11 to 0x21; in the next cycle load word from 0x20 -> 0xAABB11DD. With READ_LATENCY=3 the response arrives exactly 3 cycles after acceptance.
- Faults: half store to 0x05 with wdata 0xFFFF, then load word from 0x04 -> the store responds with resp_fault=1 and memory is unchanged. A word load from 0x06 -> resp_fault=1, rdata 0. Width 11 at DATA_WIDTH=32 -> fault.
- Wrap and throughput: DEPTH_WORDS=16, store word 0x12345678 to 0x40, load from 0x00 -> 0x12345678. Four back-to-back loads produce four consecutive resp_valid cycles, in order.
- Reset mid-operation: assert reset with 2 responses in flight and during CLEAR at counter=5 -> no stale resp_valid appears, and the clear restarts with a full DEPTH_WORDS-cycle req_ready=0 window.
